wt_store_buffer: RTL and testbench
==================================

# wt_store_buffer

Write-through store buffer between the store unit and the data-cache memory port of the 32-bit, write-through-cache CVA6 core configuration. Accepts word-aligned stores, merges stores to the same unsent word, issues them to memory in allocation order tagged with a transaction ID, and frees each entry when its write response returns. It also flags load/buffer address collisions, and reports emptiness for fences.

## Interface
- `DEPTH`, 4: number of buffer entries; must satisfy 1 ≤ DEPTH ≤ 2**TID_W.
- `PLEN`, 34: physical address width.
- `XLEN`, 32: data word width; byte enables are XLEN/8 bits wide.
- `TID_W`, 2: transaction ID width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `st_valid_i`  in  1  store request valid.
- `st_ready_o`  out  1  store accepted when valid && ready.
- `st_addr_i`  in  PLEN  store address; low log2(XLEN/8) bits are ignored.
- `st_data_i`  in  XLEN  store data, byte-lane aligned.
- `st_be_i`  in  XLEN/8  byte enables.
- `mem_req_valid_o`  out  1  write request to memory.
- `mem_req_ready_i`  in  1  memory accepts the request.
- `mem_req_addr_o`  out  PLEN  word address; low bits are zero.
- `mem_req_data_o`  out  XLEN  merged data.
- `mem_req_be_o`  out  XLEN/8  merged byte enables.
- `mem_req_tid_o`  out  TID_W  transaction ID; equals the entry index.
- `mem_rsp_valid_i`  in  1  write acknowledge.
- `mem_rsp_tid_i`  in  TID_W  ID being acknowledged.
- `ld_addr_i`  in  PLEN  load address to check.
- `ld_hit_o`  out  1  any occupied entry matches the load word address.
- `empty_o`  out  1  all entries are INVALID.

## Operation
- Each entry holds a 2-bit state, the word address, data and byte enables.
- Entry states: INVALID → VALID on allocate; VALID → SENT on mem request handshake; SENT → INVALID on a response with a matching tid.
- **Merge.** A store whose word address equals a VALID entry's address is merged into that entry.
  - Enabled bytes overwrite the entry's data; byte enables are ORed.
  - An entry handshaking on the memory port in the same cycle is not a merge target; the store allocates a new entry instead.
- **Allocate.** When no merge target exists, the store takes the lowest-index INVALID entry, and that index is pushed to the issue FIFO.
- **Full.** `st_ready_o` = merge target exists OR any entry is INVALID. Both terms are computed from registered state, so an entry freed by a response this cycle is usable next cycle, not this one.
- **Issue.** `mem_req_valid_o` is asserted when the issue FIFO is non-empty; the request fields come from the entry at the FIFO head. The FIFO pops on the handshake. Requests leave strictly in allocation order.
- **Response.** A response may arrive for any SENT entry, in any order.
  - A response whose tid names a non-SENT entry is ignored; an SVA assertion fires on it.
- `ld_hit_o` is combinational: OR over entries that are not INVALID of (entry word address == `ld_addr_i` word address).
- `empty_o` is high when every entry is INVALID; it is registered-state based.
- Entries with `st_be_i` all-zero are still accepted; the entry is allocated or merged normally.

## Timing
- Reset values:
  - `mem_req_valid_o` = 0, `empty_o` = 1, `st_ready_o` = 1, `ld_hit_o` = 0.
  - All entries INVALID; FIFO empty.
- Store accepted in cycle N: the entry is visible in cycle N+1; `mem_req_valid_o` rises at the earliest in N+1, and `ld_hit_o` reflects it from N+1.
- A merge in cycle N changes `mem_req_data_o` and `mem_req_be_o` from N+1.
- `mem_req_*` stay stable while valid and not ready, except for merges into the head entry. A merge into a stalled head entry is allowed and changes the data in the next cycle.
- Handshake in cycle N makes the entry SENT in N+1. The earliest response that can free it is in N+1, and the entry is freed in N+2.
- Simultaneous events in one cycle are handled independently: store accept, issue handshake and response each update their own entries.
- Reset asserted mid-operation: all state clears asynchronously and outstanding responses are dropped. Any response arriving after reset hits an INVALID entry and is ignored.

## Structure
- Shared package `wt_store_buffer_pkg`:
  - `wbuf_state_e` {INVALID, VALID, SENT};
  - `wbuf_entry_t` struct;
  - constant `WBUF_OFFS = $clog2(XLEN/8)`.
- Sub-module `wbuf_idx_fifo`: DEPTH-entry FIFO of log2(DEPTH)-bit indices with push, pop, head and empty. Push and pop in the same cycle are supported, and it never overflows by construction.
- The lowest-free-index selector is an inline priority encoder.

## Test plan
- **Single store, merge, issue.**
  - Stimulus: store addr 0x8000_0004, data 0xAABBCCDD, be 0xF, with `mem_req_ready_i` held low.
  - Then store addr 0x8000_0006, be 0x4, data 0x00110000.
  - Required: one request with data 0xAA11CCDD, be 0xF, tid 0.
- **Ordering and tids.**
  - Stimulus: 4 stores to distinct words with the memory stalled; release ready.
  - Required: requests in store order with tids 0,1,2,3; then `st_ready_o` = 0 for a 5th distinct store.
- **Out-of-order responses.**
  - Stimulus: responses for tids 2, 0, 3, 1.
  - Required: each entry is freed one cycle after its response; the next allocation takes index 0; `empty_o` = 1 after the last response.
- **Same-cycle events.**
  - Stimulus: with the buffer full, a response for tid 1 arrives together with a new store.
  - Required: the store is not accepted that cycle, is accepted the next cycle, and allocates index 1.
- **Load hit.**
  - Stimulus: entry 0x8000_0010 in SENT state; load at 0x8000_0012.
  - Required: `ld_hit_o` = 1; a load at 0x8000_0014 gives 0.
- **Reset.**
  - Stimulus: assert `rst_ni` low with 3 entries occupied.
  - Required: immediately `empty_o` = 1 and `mem_req_valid_o` = 0; a late response for tid 1 changes nothing.

Source files
------------

// File: rtl/wt_store_buffer_pkg.sv
// Shared types and constants for the write-through store buffer.
// The entry struct is sized for the 32-bit / 34-bit-PA configuration.
package wt_store_buffer_pkg;

    localparam int WBUF_XLEN = 32;
    localparam int WBUF_PLEN = 34;
    localparam int WBUF_OFFS = $clog2(WBUF_XLEN / 8);

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        VALID   = 2'd1,
        SENT    = 2'd2
    } wbuf_state_e;

    typedef struct packed {
        wbuf_state_e                    state;
        logic [WBUF_PLEN-WBUF_OFFS-1:0] waddr;
        logic [WBUF_XLEN-1:0]           data;
        logic [WBUF_XLEN/8-1:0]         be;
    } wbuf_entry_t;

    // Byte-lane merge: enabled lanes take the new data, the rest keep the old.
    function automatic logic [WBUF_XLEN-1:0] wbuf_merge_bytes(
        input logic [WBUF_XLEN-1:0]   old_data,
        input logic [WBUF_XLEN-1:0]   new_data,
        input logic [WBUF_XLEN/8-1:0] be
    );
        logic [WBUF_XLEN-1:0] res;
        res = old_data;
        for (int b = 0; b < WBUF_XLEN / 8; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wt_store_buffer_idx_fifo.sv
// Issue-order FIFO of entry indices. It holds at most one index per buffer
// entry, so it cannot overflow; push and pop may coincide.
module wbuf_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  logic             pop_i,
    output logic [IDX_W-1:0] head_o,
    output logic             empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_idx_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/wt_store_buffer.sv
// Write-through store buffer: merges stores into unsent words, issues them in
// allocation order with tid = entry index, frees entries on write response.
module wt_store_buffer
    import wt_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PLEN  = WBUF_PLEN,
    parameter int XLEN  = WBUF_XLEN,
    parameter int TID_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [PLEN-1:0]   st_addr_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic [XLEN/8-1:0] st_be_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [PLEN-1:0]   mem_req_addr_o,
    output logic [XLEN-1:0]   mem_req_data_o,
    output logic [XLEN/8-1:0] mem_req_be_o,
    output logic [TID_W-1:0]  mem_req_tid_o,
    input  logic              mem_rsp_valid_i,
    input  logic [TID_W-1:0]  mem_rsp_tid_i,
    input  logic [PLEN-1:0]   ld_addr_i,
    output logic              ld_hit_o,
    output logic              empty_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WA_W  = PLEN - WBUF_OFFS;

    wbuf_entry_t entry_q [DEPTH];
    wbuf_entry_t entry_d [DEPTH];

    logic [WA_W-1:0]  st_waddr, ld_waddr;
    logic [IDX_W-1:0] head_idx, free_idx, merge_idx;
    logic             fifo_empty, merge_hit, any_free;
    logic             issue_hs, st_accept, alloc, rsp_to_sent;
    logic             unused_addr_bits;

    assign st_waddr         = st_addr_i[PLEN-1:WBUF_OFFS];
    assign ld_waddr         = ld_addr_i[PLEN-1:WBUF_OFFS];
    assign unused_addr_bits = ^{st_addr_i[WBUF_OFFS-1:0], ld_addr_i[WBUF_OFFS-1:0]};

    assign mem_req_valid_o = !fifo_empty;
    assign issue_hs        = mem_req_valid_o && mem_req_ready_i;

    // The head entry leaving this cycle is no longer a merge target.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        any_free  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].state == INVALID && !any_free) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (entry_q[i].state == VALID && entry_q[i].waddr == st_waddr &&
                !(issue_hs && head_idx == IDX_W'(i)) && !merge_hit) begin
                merge_hit = 1'b1;
                merge_idx = IDX_W'(i);
            end
        end
    end

    assign st_ready_o = merge_hit || any_free;
    assign st_accept  = st_valid_i && st_ready_o;
    assign alloc      = st_accept && !merge_hit;

    always_comb begin
        ld_hit_o    = 1'b0;
        empty_o     = 1'b1;
        rsp_to_sent = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].state != INVALID) begin
                empty_o = 1'b0;
                if (entry_q[i].waddr == ld_waddr) begin
                    ld_hit_o = 1'b1;
                end
            end
            if (entry_q[i].state == SENT && mem_rsp_tid_i == TID_W'(i)) begin
                rsp_to_sent = 1'b1;
            end
        end
    end

    // Accept, issue and response each touch their own entry in a cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (issue_hs && head_idx == IDX_W'(i)) begin
                entry_d[i].state = SENT;
            end
            if (mem_rsp_valid_i && entry_q[i].state == SENT && mem_rsp_tid_i == TID_W'(i)) begin
                entry_d[i].state = INVALID;
            end
            if (st_accept && merge_hit && merge_idx == IDX_W'(i)) begin
                entry_d[i].data = wbuf_merge_bytes(entry_q[i].data, st_data_i, st_be_i);
                entry_d[i].be   = entry_q[i].be | st_be_i;
            end
            if (alloc && free_idx == IDX_W'(i)) begin
                entry_d[i].state = VALID;
                entry_d[i].waddr = st_waddr;
                entry_d[i].data  = st_data_i;
                entry_d[i].be    = st_be_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '{state: INVALID, waddr: '0, data: '0, be: '0};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    wbuf_idx_fifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_idx_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (alloc),
        .push_idx_i (free_idx),
        .pop_i      (issue_hs),
        .head_o     (head_idx),
        .empty_o    (fifo_empty)
    );

    assign mem_req_addr_o = {entry_q[head_idx].waddr, {WBUF_OFFS{1'b0}}};
    assign mem_req_data_o = entry_q[head_idx].data;
    assign mem_req_be_o   = entry_q[head_idx].be;
    assign mem_req_tid_o  = TID_W'(head_idx);

    a_rsp_to_sent: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rsp_valid_i |-> rsp_to_sent);

endmodule

// File: tb/tb_wt_store_buffer.sv
// Scoreboard bench for wt_store_buffer: a queue-based reference model predicts
// requests and status outputs; a separate monitor compares them each cycle.
module tb_wt_store_buffer;

    localparam int DEPTH = 4;
    localparam int PLEN  = 34;
    localparam int XLEN  = 32;
    localparam int TID_W = 2;
    localparam int BE_W  = XLEN / 8;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              st_valid_i = 1'b0;
    logic              st_ready_o;
    logic [PLEN-1:0]   st_addr_i = '0;
    logic [XLEN-1:0]   st_data_i = '0;
    logic [BE_W-1:0]   st_be_i = '0;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i = 1'b0;
    logic [PLEN-1:0]   mem_req_addr_o;
    logic [XLEN-1:0]   mem_req_data_o;
    logic [BE_W-1:0]   mem_req_be_o;
    logic [TID_W-1:0]  mem_req_tid_o;
    logic              mem_rsp_valid_i = 1'b0;
    logic [TID_W-1:0]  mem_rsp_tid_i = '0;
    logic [PLEN-1:0]   ld_addr_i = '0;
    logic              ld_hit_o;
    logic              empty_o;

    wt_store_buffer #(.DEPTH(DEPTH), .PLEN(PLEN), .XLEN(XLEN), .TID_W(TID_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
        .st_data_i(st_data_i), .st_be_i(st_be_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_be_o(mem_req_be_o), .mem_req_tid_o(mem_req_tid_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_tid_i(mem_rsp_tid_i),
        .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int              idx;
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
    } req_t;

    req_t            pend[$];    // allocated but not yet issued, in issue order
    req_t            exp_q[$];   // requests the DUT must present on a handshake
    bit              m_busy [DEPTH];
    bit              m_sent [DEPTH];
    logic [PLEN-1:0] m_addr [DEPTH];
    bit              e_ready = 1'b1, e_valid = 1'b0, e_empty = 1'b1, e_ldhit = 1'b0;
    bit              m_hs;
    int              m_mpos, m_free;
    req_t            m_r;
    logic [XLEN-1:0] m_mask;

    function automatic logic [PLEN-1:0] word_of(input logic [PLEN-1:0] a);
        return a & ~(PLEN'(BE_W - 1));
    endfunction

    always @(negedge clk) begin
        if (!rst_ni) begin
            pend.delete();
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                m_busy[i] = 1'b0;
                m_sent[i] = 1'b0;
            end
            e_ready = 1'b1; e_valid = 1'b0; e_empty = 1'b1; e_ldhit = 1'b0;
        end else begin
            m_hs   = (pend.size() > 0) && mem_req_ready_i;
            m_mpos = -1;
            foreach (pend[p]) begin
                if (pend[p].addr == word_of(st_addr_i) && !(m_hs && p == 0)) m_mpos = p;
            end
            m_free = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) m_free = i;
            e_ready = (m_mpos >= 0) || (m_free >= 0);
            e_valid = (pend.size() > 0);
            e_empty = 1'b1;
            e_ldhit = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i]) begin
                    e_empty = 1'b0;
                    if (m_addr[i] == word_of(ld_addr_i)) e_ldhit = 1'b1;
                end
            end
            if (m_hs) begin
                exp_q.push_back(pend[0]);
                m_sent[pend[0].idx] = 1'b1;
            end
            if (st_valid_i && e_ready) begin
                if (m_mpos >= 0) begin
                    m_r = pend[m_mpos];
                    m_mask = '0;
                    for (int b = 0; b < BE_W; b++) if (st_be_i[b]) m_mask |= XLEN'(32'hFF) << (8 * b);
                    m_r.data = (m_r.data & ~m_mask) | (st_data_i & m_mask);
                    m_r.be   = m_r.be | st_be_i;
                    pend[m_mpos] = m_r;
                end else begin
                    m_busy[m_free] = 1'b1;
                    m_addr[m_free] = word_of(st_addr_i);
                    m_r.idx  = m_free;
                    m_r.addr = word_of(st_addr_i);
                    m_r.data = st_data_i;
                    m_r.be   = st_be_i;
                    pend.push_back(m_r);
                end
            end
            if (m_hs) void'(pend.pop_front());
            if (mem_rsp_valid_i && m_sent[mem_rsp_tid_i]) begin
                m_busy[mem_rsp_tid_i] = 1'b0;
                m_sent[mem_rsp_tid_i] = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    req_t mon_r;
    always @(negedge clk) begin
        #1;
        check("st_ready", st_ready_o, e_ready);
        check("req_valid", mem_req_valid_o, e_valid);
        check("empty", empty_o, e_empty);
        check("ld_hit", ld_hit_o, e_ldhit);
        if (rst_ni && mem_req_valid_o && mem_req_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req actual=tid%0d required=none t=%0t", mem_req_tid_o, $time);
            end else begin
                mon_r = exp_q.pop_front();
                check("req_addr", mem_req_addr_o, mon_r.addr);
                check("req_data", mem_req_data_o, mon_r.data);
                check("req_be", mem_req_be_o, mon_r.be);
                check("req_tid", mem_req_tid_o, mon_r.idx);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #2;
    endtask

    task automatic do_store(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d, input logic [BE_W-1:0] be);
        bit done;
        done = 1'b0;
        st_valid_i = 1'b1; st_addr_i = a; st_data_i = d; st_be_i = be;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (st_ready_o) done = 1'b1;
            @(posedge clk);
            #1;
        end
        st_valid_i = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL store_timeout actual=not_accepted required=accepted addr=0x%0h", a);
        end
    endtask

    task automatic respond(input int tid);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_tid_i   = TID_W'(tid);
        step(1);
        mem_rsp_valid_i = 1'b0;
    endtask

    function automatic bit model_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < DEPTH; i++) b |= m_busy[i];
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pick;
        step(3);
        rst_ni = 1'b1;
        step(1);

        // single store + merge into unsent word
        do_store(34'h0_8000_0004, 32'hAABBCCDD, 4'hF);
        do_store(34'h0_8000_0006, 32'h0011_0000, 4'h4);
        peek();
        check("merge_data", mem_req_data_o, 32'hAA11CCDD);
        check("merge_be", mem_req_be_o, 4'hF);
        check("merge_tid", mem_req_tid_o, 0);
        step(1);
        mem_req_ready_i = 1'b1; step(1);
        mem_req_ready_i = 1'b0; step(1);
        respond(0);
        step(2);

        // fill with four distinct words, then try a fifth
        do_store(34'h0_8000_0010, 32'h1111_0010, 4'hF);
        do_store(34'h0_8000_0020, 32'h2222_0020, 4'h3);
        do_store(34'h0_8000_0030, 32'h3333_0030, 4'hC);
        do_store(34'h0_8000_0040, 32'h4444_0040, 4'h0);
        st_valid_i = 1'b1; st_addr_i = 34'h0_8000_0050; st_be_i = 4'hF;
        peek();
        check("full_ready", st_ready_o, 1'b0);
        step(1);
        st_valid_i = 1'b0;
        mem_req_ready_i = 1'b1; step(5);
        mem_req_ready_i = 1'b0; step(1);

        // load hit against a SENT entry
        ld_addr_i = 34'h0_8000_0012;
        peek();
        check("ld_hit_sent", ld_hit_o, 1'b1);
        step(1);
        ld_addr_i = 34'h0_8000_0014;
        peek();
        check("ld_miss", ld_hit_o, 1'b0);
        step(1);

        // out-of-order responses
        respond(2);
        peek();
        check("freed_after_rsp", st_ready_o, 1'b1);
        step(1);
        respond(0);
        respond(3);
        respond(1);
        peek();
        check("empty_after_rsps", empty_o, 1'b1);
        step(1);

        // refill (allocates from index 0), issue all, then response + store same cycle
        do_store(34'h0_8000_0100, $urandom, 4'hF);
        do_store(34'h0_8000_0104, $urandom, 4'h1);
        do_store(34'h0_8000_0108, $urandom, 4'h2);
        do_store(34'h0_8000_010C, $urandom, 4'h8);
        mem_req_ready_i = 1'b1; step(4);
        mem_req_ready_i = 1'b0; step(1);
        mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd1;
        st_valid_i = 1'b1; st_addr_i = 34'h0_8000_0200; st_data_i = 32'hCAFEF00D; st_be_i = 4'hF;
        peek();
        check("same_cycle_ready", st_ready_o, 1'b0);
        step(1);
        mem_rsp_valid_i = 1'b0;
        peek();
        check("next_cycle_ready", st_ready_o, 1'b1);
        step(1);
        st_valid_i = 1'b0;
        peek();
        check("realloc_tid", mem_req_tid_o, 1);
        step(1);
        mem_req_ready_i = 1'b1; step(1);
        mem_req_ready_i = 1'b0; step(1);
        respond(0); respond(2); respond(3); respond(1);
        step(1);

        // randomized traffic over a small address pool
        for (int c = 0; c < 3000; c++) begin
            st_valid_i      = ($urandom_range(0, 2) != 0);
            st_addr_i       = 34'h0_8000_0000 + PLEN'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
            st_data_i       = $urandom;
            st_be_i         = BE_W'($urandom);
            mem_req_ready_i = ($urandom_range(0, 3) == 0);
            ld_addr_i       = 34'h0_8000_0000 + PLEN'($urandom_range(0, 7) * 4);
            mem_rsp_valid_i = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                pick = $urandom_range(0, DEPTH - 1);
                if (m_sent[pick]) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_tid_i   = TID_W'(pick);
                end
            end
            step(1);
        end

        // drain
        st_valid_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        for (int c = 0; c < 200 && model_busy(); c++) begin
            mem_rsp_valid_i = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_sent[i] && !mem_rsp_valid_i) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_tid_i   = TID_W'(i);
                end
            end
            step(1);
        end
        mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b0;
        step(2);
        peek();
        check("drained_empty", empty_o, 1'b1);
        step(1);

        // reset with three occupied entries, two of them SENT
        do_store(34'h0_8000_0300, $urandom, 4'hF);
        do_store(34'h0_8000_0304, $urandom, 4'hF);
        do_store(34'h0_8000_0308, $urandom, 4'hF);
        mem_req_ready_i = 1'b1; step(2);
        mem_req_ready_i = 1'b0; step(1);
        rst_ni = 1'b0;
        #1;
        check("rst_empty", empty_o, 1'b1);
        check("rst_req_valid", mem_req_valid_o, 1'b0);
        step(1);
        mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd1;
        step(1);
        mem_rsp_valid_i = 1'b0;
        step(1);
        rst_ni = 1'b1;
        step(2);
        peek();
        check("post_rst_empty", empty_o, 1'b1);
        check("post_rst_ready", st_ready_o, 1'b1);
        step(1);
        do_store(34'h0_8000_0400, 32'h0BADBEEF, 4'h5);
        mem_req_ready_i = 1'b1; step(2);
        mem_req_ready_i = 1'b0; step(1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
